result_queue: RTL and testbench
===============================

// Module: result_queue
// PURPOSE
//  Upstream feeder for the nibble output loader. Buffers {mode, wordA, wordB} result records
//  from the watchdog core in a small FIFO. Dispatches one record at a time using a
//  start/busy handshake, so back-to-back results are not lost while the loader streams.
// PARAMETERS
//  W      32  data word width (loader nibble path requires 32)
//  DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    async active-low reset
//  ena        in   1    dispatch enable; FSM holds state when 0 (pushes still accepted)
//  push_valid in   1    record push request
//  push_mode  in   3    record mode
//  push_a     in   W    record word A
//  push_b     in   W    record word B
//  push_ready out  1    =1 when FIFO not full (combinational from count)
//  ld_busy    in   1    loader busy
//  ld_start   out  1    loader start, level-held until ld_busy seen
//  ld_mode    out  3    head mode, registered, stable ISSUE..WAIT_DONE
//  ld_word_a  out  W    head word A, registered, stable ISSUE..WAIT_DONE
//  ld_word_b  out  W    head word B, registered, stable ISSUE..WAIT_DONE
//  level      out  $clog2(DEPTH)+1  current entry count
//  drop_cnt   out  8    rejected-push counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FIFO empty, ptrs=0, level=0, state IDLE, ld_start=0, ld_mode/ld_word_a/ld_word_b=0,
//    drop_cnt=0, push_ready=1.
//  - Push: accepted on an edge with push_valid&push_ready; written at wr_ptr; wr_ptr wraps mod DEPTH.
//    push_valid while full: record dropped, FIFO unchanged.
//  - Full is judged on the pre-edge count. A push coinciding with the pop of a full FIFO is rejected.
//  - FSM advances only on edges where ena=1:
//    IDLE: level>0 -> latch head into ld_*, ld_start<=1, go to ISSUE.
//    ISSUE: hold ld_start=1. ld_busy=1 -> ld_start<=0, go to WAIT_DONE.
//    WAIT_DONE: ld_busy=0 -> pop (rd_ptr++, level--), go to IDLE.
//    Illegal state -> IDLE, ld_start=0.
//  - Latency: push accepted at edge N into an empty FIFO with state IDLE and ena=1
//    -> ld_start high after edge N+1.
//  - Minimum 1 IDLE cycle between records.
//  - Head entry is popped only after the loader finishes, so ld_word_b stays valid through the B phase.
//  - Simultaneous push+pop (not full): level unchanged, both pointers advance.
//  - ld_busy high in IDLE (foreign start): ignored. The block waits in IDLE only if level=0;
//    otherwise it issues and ISSUE waits for the busy edge.
//  - Reset mid-record: everything clears; the in-flight record is lost. No partial pop.
// CONFIGURATION
//  RESULT_QUEUE_STATS_EN
//   defined: drop_cnt increments on each rejected push and saturates at 8'hFF.
//   undefined: drop_cnt tied to 0 and no counter logic; port still present.
// STRUCTURE
//  result_queue_pkg:
//   - rq_entry_t packed struct {mode[2:0], word_a[W-1:0], word_b[W-1:0]}
//   - rq_state_t enum {RQ_IDLE, RQ_ISSUE, RQ_WAIT_DONE}
//  Sub-module rq_fifo:
//   - storage array, wr/rd pointers, level, full/empty
//   - push/pop inputs, head rq_entry_t output
//  Top: dispatch FSM, ld_* output registers, drop counter.
// TESTING
//  1. Reset, then push {mode=3'b101, A=32'h12345678, B=32'h9ABCDEF0}, ena=1
//     -> ld_start high 1 edge later with those values;
//     -> bench model raises ld_busy 1 cycle later -> ld_start drops next edge;
//     -> busy 16 cycles, then level 1->0.
//  2. Burst of 5 pushes (DEPTH=4, busy model stalled)
//     -> push_ready=0 after 4th accepted; 5th dropped;
//     -> drop_cnt=1 with STATS_EN, 0 without; all 4 records dispatched in order.
//  3. ena=0 for 10 cycles with level=2 -> no ld_start, no pop;
//     ena=1 -> dispatch resumes and ld_* match the oldest entry.
//  4. Full FIFO, push on the same edge as a pop -> push rejected, level=3 after the edge.
//  5. Assert rst_n=0 in WAIT_DONE with level=3 -> immediate ld_start=0, level=0, outputs 0;
//     next push dispatched normally.
//  6. 300 pushes while full with STATS_EN -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/result_queue_pkg.sv
// Shared types for the result queue: FIFO record layout and dispatch FSM states.
`timescale 1ns/1ps
package result_queue_pkg;

  localparam int RQ_W      = 32;
  localparam int RQ_MODE_W = 3;
  localparam logic [7:0] RQ_DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [RQ_MODE_W-1:0] mode;
    logic [RQ_W-1:0]      word_a;
    logic [RQ_W-1:0]      word_b;
  } rq_entry_t;

  typedef enum logic [1:0] {
    RQ_IDLE      = 2'd0,
    RQ_ISSUE     = 2'd1,
    RQ_WAIT_DONE = 2'd2
  } rq_state_t;

endpackage

// File: rtl/rq_fifo.sv
// Record FIFO for result_queue: power-of-2 depth, wrapping pointers, explicit level count.
`timescale 1ns/1ps
module rq_fifo
  import result_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  rq_entry_t     push_data_i,
  input  logic          pop_i,
  output rq_entry_t     head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  rq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            push_acc, pop_acc;

  // Full is judged on the pre-edge count, so a push racing a pop of a full FIFO is refused.
  assign full_o   = (level_q == LW'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: storage is deliberately left unreset; the level count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/result_queue.sv
// Buffers {mode, wordA, wordB} results and dispatches them to the nibble loader via start/busy.
// Optional RESULT_QUEUE_STATS_EN: saturating 8-bit counter of rejected pushes on drop_cnt.
`timescale 1ns/1ps
module result_queue
  import result_queue_pkg::*;
#(
  parameter int W     = RQ_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   push_valid,
  input  logic [2:0]             push_mode,
  input  logic [W-1:0]           push_a,
  input  logic [W-1:0]           push_b,
  output logic                   push_ready,
  input  logic                   ld_busy,
  output logic                   ld_start,
  output logic [2:0]             ld_mode,
  output logic [W-1:0]           ld_word_a,
  output logic [W-1:0]           ld_word_b,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt
);

  rq_entry_t push_entry, head;
  rq_entry_t ld_q, ld_d;
  rq_state_t state_q, state_d;
  logic      ld_start_q, ld_start_d;
  logic      pop, full, empty;

  assign push_entry = '{mode: push_mode, word_a: push_a, word_b: push_b};

  rq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_valid),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign push_ready = !full;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ld_start_d = ld_start_q;
    ld_d       = ld_q;
    pop        = 1'b0;
    if (ena) begin
      case (state_q)
        RQ_IDLE: begin
          if (!empty) begin
            ld_d       = head;
            ld_start_d = 1'b1;
            state_d    = RQ_ISSUE;
          end
        end
        RQ_ISSUE: begin
          ld_start_d = 1'b1;
          if (ld_busy) begin
            ld_start_d = 1'b0;
            state_d    = RQ_WAIT_DONE;
          end
        end
        RQ_WAIT_DONE: begin
          // The head leaves the FIFO only once the loader has finished streaming it.
          if (!ld_busy) begin
            pop     = 1'b1;
            state_d = RQ_IDLE;
          end
        end
        default: begin
          ld_start_d = 1'b0;
          state_d    = RQ_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RQ_IDLE;
      ld_start_q <= 1'b0;
      ld_q       <= '0;
    end else begin
      state_q    <= state_d;
      ld_start_q <= ld_start_d;
      ld_q       <= ld_d;
    end
  end

  assign ld_start  = ld_start_q;
  assign ld_mode   = ld_q.mode;
  assign ld_word_a = ld_q.word_a;
  assign ld_word_b = ld_q.word_b;

`ifdef RESULT_QUEUE_STATS_EN
  logic [7:0] drop_q;
  logic       rejected;

  assign rejected = push_valid && full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 drop_q <= '0;
    else if (rejected && drop_q != RQ_DROP_MAX) drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_result_queue.sv
// Directed self-checking bench for result_queue; expectations follow RESULT_QUEUE_STATS_EN.
`timescale 1ns/1ps
module tb_result_queue;

`ifdef RESULT_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        push_valid;
  logic [2:0]  push_mode;
  logic [31:0] push_a, push_b;
  logic        push_ready;
  logic        ld_busy;
  logic        ld_start;
  logic [2:0]  ld_mode;
  logic [31:0] ld_word_a, ld_word_b;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  result_queue #(.W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .push_valid (push_valid),
    .push_mode  (push_mode),
    .push_a     (push_a),
    .push_b     (push_b),
    .push_ready (push_ready),
    .ld_busy    (ld_busy),
    .ld_start   (ld_start),
    .ld_mode    (ld_mode),
    .ld_word_a  (ld_word_a),
    .ld_word_b  (ld_word_b),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    push_valid = 1'b1;
    push_mode  = m;
    push_a     = a;
    push_b     = b;
    tick();
    push_valid = 1'b0;
  endtask

  // Acts as the loader for one record: wait for start, check payload, run busy, let it pop.
  task automatic serve(input string tag, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] b, input int busy_cycles, input int exp_level);
    int n = 0;
    while (!ld_start && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_start"}, ld_start, 1'b1);
    check({tag, "_mode"},  ld_mode, m);
    check({tag, "_a"},     ld_word_a, a);
    check({tag, "_b"},     ld_word_b, b);
    ld_busy = 1'b1;
    tick();
    check({tag, "_start_drop"}, ld_start, 1'b0);
    repeat (busy_cycles - 1) tick();
    check({tag, "_b_held"}, ld_word_b, b);
    ld_busy = 1'b0;
    tick();
    check({tag, "_level"}, level, exp_level);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; push_valid = 1'b0; ld_busy = 1'b0;
    push_mode = '0; push_a = '0; push_b = '0;
    #2;
    check("rst_start", ld_start, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_ready", push_ready, 1'b1);
    check("rst_out", {ld_mode, ld_word_a, ld_word_b} == '0, 1'b1);
    check("rst_drop", drop_cnt, 8'd0);
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // 1: single record, start one edge after the accepting edge
    push(3'b101, 32'h1234_5678, 32'h9ABC_DEF0);
    check("t1_level", level, 3'd1);
    check("t1_no_start_yet", ld_start, 1'b0);
    tick();
    check("t1_start", ld_start, 1'b1);
    check("t1_mode", ld_mode, 3'b101);
    check("t1_a", ld_word_a, 32'h1234_5678);
    check("t1_b", ld_word_b, 32'h9ABC_DEF0);
    ld_busy = 1'b1;
    tick();
    check("t1_start_drop", ld_start, 1'b0);
    repeat (15) tick();
    check("t1_level_busy", level, 3'd1);
    ld_busy = 1'b0;
    tick();
    check("t1_level_pop", level, 3'd0);

    // 2: burst of 5 with the loader stalled
    for (int i = 0; i < 5; i++) begin
      push(3'(i), 32'hA000_0000 + i, 32'hB000_0000 + i);
      if (i == 3) begin
        check("t2_ready_full", push_ready, 1'b0);
        check("t2_level_full", level, 3'd4);
      end
    end
    if (STATS) exp_drop++;
    check("t2_level_after", level, 3'd4);
    check("t2_drop", drop_cnt, 8'(exp_drop));
    serve("t2_r0", 3'd0, 32'hA000_0000, 32'hB000_0000, 3, 3);
    serve("t2_r1", 3'd1, 32'hA000_0001, 32'hB000_0001, 2, 2);
    serve("t2_r2", 3'd2, 32'hA000_0002, 32'hB000_0002, 4, 1);
    serve("t2_r3", 3'd3, 32'hA000_0003, 32'hB000_0003, 1, 0);

    // 3: dispatch frozen by ena=0, pushes still accepted
    ena = 1'b0;
    push(3'd6, 32'hC000_0001, 32'hD000_0001);
    push(3'd7, 32'hC000_0002, 32'hD000_0002);
    repeat (10) tick();
    check("t3_no_start", ld_start, 1'b0);
    check("t3_level_hold", level, 3'd2);
    ena = 1'b1;
    serve("t3_r0", 3'd6, 32'hC000_0001, 32'hD000_0001, 2, 1);
    serve("t3_r1", 3'd7, 32'hC000_0002, 32'hD000_0002, 2, 0);

    // 4: push on the same edge as the pop of a full FIFO is refused
    ena = 1'b0;
    for (int i = 4; i < 8; i++) push(3'(i), 32'hE000_0000 + i, 32'hF000_0000 + i);
    check("t4_ready_full", push_ready, 1'b0);
    ena = 1'b1;
    tick();
    check("t4_head_a", ld_word_a, 32'hE000_0004);
    ld_busy = 1'b1;
    tick();
    ld_busy    = 1'b0;
    push_valid = 1'b1;
    push_mode  = 3'd1;
    push_a     = 32'hDEAD_0001;
    push_b     = 32'hDEAD_0002;
    tick();
    push_valid = 1'b0;
    if (STATS) exp_drop++;
    check("t4_level", level, 3'd3);
    check("t4_ready", push_ready, 1'b1);
    check("t4_drop", drop_cnt, 8'(exp_drop));

    // 5: reset while waiting for the loader
    tick();
    check("t5_head_a", ld_word_a, 32'hE000_0005);
    ld_busy = 1'b1;
    tick();
    check("t5_level_wait", level, 3'd3);
    rst_n = 1'b0;
    #1;
    exp_drop = 0;
    check("t5_start", ld_start, 1'b0);
    check("t5_level", level, 3'd0);
    check("t5_out", {ld_mode, ld_word_a, ld_word_b} == '0, 1'b1);
    check("t5_drop", drop_cnt, 8'd0);
    ld_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push(3'd2, 32'h5555_AAAA, 32'hAAAA_5555);
    serve("t5_r0", 3'd2, 32'h5555_AAAA, 32'hAAAA_5555, 3, 0);

    // 6: drop counter saturation
    ena = 1'b0;
    for (int i = 0; i < 4; i++) push(3'(i), 32'h0 + i, 32'h100 + i);
    push_valid = 1'b1;
    repeat (254) tick();
    check("t6_drop_254", drop_cnt, STATS ? 8'd254 : 8'd0);
    repeat (46) tick();
    push_valid = 1'b0;
    check("t6_drop_sat", drop_cnt, STATS ? 8'hFF : 8'd0);
    check("t6_level", level, 3'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
